// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU: datapath width, opcode encoding and
// signed-overflow helpers.
package alu_pkg;

    localparam int unsigned WIDTH = 8;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_ROL  = 4'd11,
        ALU_ROR  = 4'd12,
        ALU_INC  = 4'd13,
        ALU_DEC  = 4'd14,
        ALU_NOT  = 4'd15
    } alu_func_e;

    // Addition overflows when both operands share a sign the result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Subtraction overflows when operand signs differ and the result flips away from a.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_8bit_core.sv
// Combinational ALU core: produces the next result and status flags from the
// operands and opcode. Holds no state.
module alu_8bit_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       func_i,
    output logic [WIDTH-1:0] res_o,
    output logic             zf_o,
    output logic             of_o,
    output logic             cf_o,
    output logic             sf_o
);

    localparam int unsigned ShW = $clog2(WIDTH);

    logic [ShW-1:0]     shamt;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [WIDTH:0]     inc_full;
    logic [WIDTH:0]     dec_full;
    logic [WIDTH:0]     sll_full;
    logic [WIDTH:0]     srl_full;
    logic [WIDTH:0]     sra_full;
    logic [2*WIDTH-1:0] rol_full;
    logic [2*WIDTH-1:0] ror_full;
    logic               shamt_nz;
    logic               slt;
    logic               sltu;

    logic [WIDTH-1:0]   res_c;
    logic               of_c;
    logic               cf_c;

    // Upper bits of b are ignored for shifts and rotates.
    assign shamt    = b_i[ShW-1:0];
    assign shamt_nz = |shamt;

    // One extra bit on the arithmetic paths captures carry/borrow.
    assign add_full = {1'b0, a_i} + {1'b0, b_i};
    assign sub_full = {1'b0, a_i} - {1'b0, b_i};
    assign inc_full = {1'b0, a_i} + (WIDTH + 1)'(1);
    assign dec_full = {1'b0, a_i} - (WIDTH + 1)'(1);

    // Shifts run on a widened operand so the last bit shifted out lands in the
    // extra bit; a zero amount leaves that bit clear, giving cf=0 for free.
    assign sll_full = {1'b0, a_i} << shamt;
    assign srl_full = {a_i, 1'b0} >> shamt;
    assign sra_full = $signed({a_i, 1'b0}) >>> shamt;

    // Rotates use a doubled copy of a; the wanted window is one half.
    assign rol_full = {a_i, a_i} << shamt;
    assign ror_full = {a_i, a_i} >> shamt;

    assign slt  = $signed(a_i) < $signed(b_i);
    assign sltu = a_i < b_i;

    // Opcode decode; cf/of default to 0 for ops that do not define them.
    always_comb begin
        res_c = '0;
        of_c  = 1'b0;
        cf_c  = 1'b0;
        unique case (alu_func_e'(func_i))
            ALU_ADD: begin
                res_c = add_full[WIDTH-1:0];
                cf_c  = add_full[WIDTH];
                of_c  = add_ovf(a_i[WIDTH-1], b_i[WIDTH-1], add_full[WIDTH-1]);
            end
            ALU_SUB: begin
                res_c = sub_full[WIDTH-1:0];
                cf_c  = sub_full[WIDTH];
                of_c  = sub_ovf(a_i[WIDTH-1], b_i[WIDTH-1], sub_full[WIDTH-1]);
            end
            ALU_AND:  res_c = a_i & b_i;
            ALU_OR:   res_c = a_i | b_i;
            ALU_XOR:  res_c = a_i ^ b_i;
            ALU_NOR:  res_c = ~(a_i | b_i);
            ALU_SLT:  res_c = {{(WIDTH - 1){1'b0}}, slt};
            ALU_SLTU: res_c = {{(WIDTH - 1){1'b0}}, sltu};
            ALU_SLL: begin
                res_c = sll_full[WIDTH-1:0];
                cf_c  = sll_full[WIDTH];
            end
            ALU_SRL: begin
                res_c = srl_full[WIDTH:1];
                cf_c  = srl_full[0];
            end
            ALU_SRA: begin
                res_c = sra_full[WIDTH:1];
                cf_c  = sra_full[0];
            end
            ALU_ROL: begin
                res_c = rol_full[2*WIDTH-1:WIDTH];
                cf_c  = shamt_nz & rol_full[WIDTH];
            end
            ALU_ROR: begin
                res_c = ror_full[WIDTH-1:0];
                cf_c  = shamt_nz & ror_full[WIDTH-1];
            end
            ALU_INC: begin
                res_c = inc_full[WIDTH-1:0];
                cf_c  = inc_full[WIDTH];
                of_c  = add_ovf(a_i[WIDTH-1], 1'b0, inc_full[WIDTH-1]);
            end
            ALU_DEC: begin
                res_c = dec_full[WIDTH-1:0];
                cf_c  = dec_full[WIDTH];
                of_c  = sub_ovf(a_i[WIDTH-1], 1'b0, dec_full[WIDTH-1]);
            end
            ALU_NOT:  res_c = ~a_i;
            default: begin
                res_c = '0;
            end
        endcase
    end

    assign res_o = res_c;
    assign zf_o  = ~|res_c;
    assign of_o  = of_c;
    assign cf_o  = cf_c;
    assign sf_o  = res_c[WIDTH-1];

endmodule

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: the combinational core followed by async-reset
// result and flag registers, giving one cycle of latency.
module alu_8bit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       func,
    output logic [WIDTH-1:0] res,
    output logic             zf,
    output logic             of,
    output logic             cf,
    output logic             sf
);

    logic [WIDTH-1:0] res_d, res_q;
    logic             zf_d, zf_q;
    logic             of_d, of_q;
    logic             cf_d, cf_q;
    logic             sf_d, sf_q;

    alu_8bit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i    (a),
        .b_i    (b),
        .func_i (func),
        .res_o  (res_d),
        .zf_o   (zf_d),
        .of_o   (of_d),
        .cf_o   (cf_d),
        .sf_o   (sf_d)
    );

    // Output registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            zf_q  <= 1'b0;
            of_q  <= 1'b0;
            cf_q  <= 1'b0;
            sf_q  <= 1'b0;
        end else begin
            res_q <= res_d;
            zf_q  <= zf_d;
            of_q  <= of_d;
            cf_q  <= cf_d;
            sf_q  <= sf_d;
        end
    end

    assign res = res_q;
    assign zf  = zf_q;
    assign of  = of_q;
    assign cf  = cf_q;
    assign sf  = sf_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed vector table, reset and timing
// sequences, and a back-to-back sweep of all opcodes against a reference model.
module tb_alu_8bit;

    typedef struct {
        string      name;
        logic [3:0] func;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       zf;
        logic       of;
        logic       cf;
        logic       sf;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] func;
    logic [7:0] res;
    logic       zf;
    logic       of;
    logic       cf;
    logic       sf;

    int n_checks;
    int n_errors;

    vec_t vecs[$];

    alu_8bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .func  (func),
        .res   (res),
        .zf    (zf),
        .of    (of),
        .cf    (cf),
        .sf    (sf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] e_res, input logic e_zf,
                         input logic e_of, input logic e_cf, input logic e_sf);
        n_checks++;
        if (res !== e_res || zf !== e_zf || of !== e_of || cf !== e_cf || sf !== e_sf) begin
            n_errors++;
            $display("FAIL %s: got res=%02h zf=%b of=%b cf=%b sf=%b, want res=%02h zf=%b of=%b cf=%b sf=%b",
                     name, res, zf, of, cf, sf, e_res, e_zf, e_of, e_cf, e_sf);
        end
    endtask

    task automatic add_vec(input string name, input logic [3:0] f, input logic [7:0] va,
                           input logic [7:0] vb, input logic [7:0] r, input logic z,
                           input logic o, input logic c, input logic s);
        vec_t v;
        v.name = name; v.func = f; v.a = va; v.b = vb;
        v.res = r; v.zf = z; v.of = o; v.cf = c; v.sf = s;
        vecs.push_back(v);
    endtask

    // Reference model written bit-by-bit, independent of the RTL structure.
    task automatic model(input logic [3:0] f, input logic [7:0] ma, input logic [7:0] mb,
                         output logic [7:0] r, output logic o, output logic c);
        int         s;
        int         n;
        logic [7:0] t;
        r = 8'h00; o = 1'b0; c = 1'b0;
        n = int'(mb[2:0]);
        t = ma;
        case (f)
            4'd0: begin
                s = int'(ma) + int'(mb);
                r = s[7:0]; c = (s > 255);
                o = (ma[7] == mb[7]) && (r[7] != ma[7]);
            end
            4'd1: begin
                s = int'(ma) - int'(mb);
                r = s[7:0]; c = (ma < mb);
                o = (ma[7] != mb[7]) && (r[7] != ma[7]);
            end
            4'd2: r = ma & mb;
            4'd3: r = ma | mb;
            4'd4: r = ma ^ mb;
            4'd5: r = ~(ma | mb);
            4'd6: r = ($signed(ma) < $signed(mb)) ? 8'h01 : 8'h00;
            4'd7: r = (ma < mb) ? 8'h01 : 8'h00;
            4'd8: begin
                for (int i = 0; i < n; i++) begin c = t[7]; t = {t[6:0], 1'b0}; end
                r = t;
            end
            4'd9: begin
                for (int i = 0; i < n; i++) begin c = t[0]; t = {1'b0, t[7:1]}; end
                r = t;
            end
            4'd10: begin
                for (int i = 0; i < n; i++) begin c = t[0]; t = {t[7], t[7:1]}; end
                r = t;
            end
            4'd11: begin
                for (int i = 0; i < n; i++) t = {t[6:0], t[7]};
                r = t; c = (n != 0) ? t[0] : 1'b0;
            end
            4'd12: begin
                for (int i = 0; i < n; i++) t = {t[0], t[7:1]};
                r = t; c = (n != 0) ? t[7] : 1'b0;
            end
            4'd13: begin
                r = ma + 8'h01; c = (ma == 8'hFF); o = (ma == 8'h7F);
            end
            4'd14: begin
                r = ma - 8'h01; c = (ma == 8'h00); o = (ma == 8'h80);
            end
            default: r = ~ma;
        endcase
    endtask

    initial begin
        logic [7:0] m_res;
        logic       m_of;
        logic       m_cf;

        n_checks = 0;
        n_errors = 0;

        //       name           func   a      b      res    zf    of    cf    sf
        add_vec("sub_eq",      4'd1,  8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec("or",          4'd3,  8'h05, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec("add_ovf",     4'd0,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        add_vec("add_carry",   4'd0,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        add_vec("sub_borrow",  4'd1,  8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b1);
        add_vec("sub_ovf",     4'd1,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec("and",         4'd2,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec("xor",         4'd4,  8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_vec("nor",         4'd5,  8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        add_vec("slt",         4'd6,  8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec("sltu",        4'd7,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec("sll1",        4'd8,  8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
        add_vec("sll7",        4'd8,  8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
        add_vec("sra3",        4'd10, 8'h80, 8'h03, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_vec("sra1",        4'd10, 8'h81, 8'h01, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b1);
        add_vec("ror1",        4'd12, 8'h01, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
        add_vec("srl0",        4'd9,  8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        add_vec("srl_hib",     4'd9,  8'h03, 8'hF9, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        add_vec("rol1",        4'd11, 8'h81, 8'h01, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
        add_vec("rol0",        4'd11, 8'h81, 8'h08, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
        add_vec("inc_ovf",     4'd13, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        add_vec("inc_wrap",    4'd13, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        add_vec("dec_wrap",    4'd14, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
        add_vec("dec_ovf",     4'd14, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec("not",         4'd15, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Power-on reset: outputs cleared with no clock edge needed.
        rst_n = 1'b0; a = 8'h00; b = 8'h00; func = 4'd0;
        #1;
        check("reset_init", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table.
        foreach (vecs[i]) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; func = vecs[i].func;
            @(posedge clk); #1;
            check(vecs[i].name, vecs[i].res, vecs[i].zf, vecs[i].of, vecs[i].cf, vecs[i].sf);
        end

        // Reset mid-operation: load a non-zero result, then drop rst_n between edges.
        @(negedge clk);
        a = 8'h7F; b = 8'h01; func = 4'd0;
        @(posedge clk); #1;
        check("pre_reset", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("reset_held", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Release, then SUB 5-5 lands on the first edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        a = 8'h05; b = 8'h05; func = 4'd1;
        @(posedge clk); #1;
        check("post_reset_sub", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Timing: new OR inputs must not show before the next edge.
        @(negedge clk);
        func = 4'd3;
        #1;
        check("or_before_edge", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("or_after_edge", 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back sweep: new opcode every cycle, random operands.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            a    = 8'($urandom_range(0, 255));
            b    = 8'($urandom_range(0, 255));
            func = 4'(i % 16);
            model(func, a, b, m_res, m_of, m_cf);
            @(posedge clk); #1;
            check($sformatf("b2b_%0d_f%0d", i, i % 16), m_res, (m_res == 8'h00), m_of, m_cf,
                  m_res[7]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, want completion within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_8bit.md
Name: alu_8bit

Overview:
8-bit registered arithmetic/logic unit for the single-cycle MIPS datapath.
- Computes one of 16 operations on operands a and b, selected by func.
- Registers the result and four status flags (zero, overflow, carry, sign) on each rising clock edge.
- Purely datapath: no handshake and no internal state beyond the output registers.

Parameters:
- WIDTH, 8, operand/result width; only 8 is required to be supported and verified.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- a  input  8  operand A.
- b  input  8  operand B; bits [2:0] give the shift/rotate amount.
- func  input  4  operation select.
- res  output  8  registered result.
- zf  output  1  zero flag; 1 when res == 0.
- of  output  1  signed overflow flag.
- cf  output  1  carry/borrow/shift-out flag.
- sf  output  1  sign flag; equals res[7].

Behaviour:
- Reset: while rst_n=0, res=0, zf=0, of=0, cf=0, sf=0, applied immediately and asynchronously. First update occurs on the first rising clk edge after rst_n deasserts.
- Latency: 1 cycle. Inputs sampled at rising edge N; res and flags valid after edge N and held until edge N+1. A new operation can start every cycle.
- func encoding, 8-bit wrap-around arithmetic:
  - 0 ADD: a+b; cf=carry out of bit 7; of=signed overflow.
  - 1 SUB: a-b; cf=borrow (1 iff a<b unsigned); of=signed overflow.
  - 2 AND: a&b.
  - 3 OR: a|b.
  - 4 XOR: a^b.
  - 5 NOR: ~(a|b).
  - 6 SLT: res=1 if a<b signed, else 0.
  - 7 SLTU: res=1 if a<b unsigned, else 0.
  - 8 SLL: a<<b[2:0]; cf=last bit shifted out.
  - 9 SRL: a>>b[2:0], zero-filled; cf=last bit shifted out.
  - 10 SRA: a>>>b[2:0], sign-filled; cf=last bit shifted out.
  - 11 ROL: rotate a left by b[2:0]; cf=res[0].
  - 12 ROR: rotate a right by b[2:0]; cf=res[7].
  - 13 INC: a+1; cf/of as ADD with b=1.
  - 14 DEC: a-1; cf/of as SUB with b=1.
  - 15 NOT: ~a.
- Default flag values: cf=0 and of=0 for every op not listed with them above, and for any shift/rotate with amount 0.
- zf and sf are always derived from the new result.
- Signed overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operand signs differ and the result sign differs from a.
- b[7:3] is ignored by shift/rotate ops.

Decomposition:
- Shared package alu_pkg holds the func opcode constants (ALU_ADD … ALU_NOT) and WIDTH.
- Combinational sub-module alu_8bit_core computes res_next and flags_next. The top-level alu_8bit adds only the async-reset output registers.

Test Plan:
- Reset: assert rst_n=0 mid-operation → all outputs 0 immediately without a clock edge. Release, then a=5, b=5, func=1 → after next edge res=0, zf=1, cf=0, of=0, sf=0.
- OR and cycle timing: a=5, b=5, func=3 → res=5, zf=0, cf=0, of=0, sf=0, appearing exactly one edge after sampling.
- Add/sub boundaries:
  - ADD 0x7F+0x01 → res=0x80, of=1, sf=1, cf=0.
  - ADD 0xFF+0x01 → res=0, zf=1, cf=1, of=0.
  - SUB 0x03-0x05 → res=0xFE, cf=1, sf=1.
  - SUB 0x80-0x01 → res=0x7F, of=1.
- Compare: SLT a=0xFF, b=0x01 → res=1. SLTU with the same operands → res=0.
- Shift/rotate:
  - SLL a=0x81, b=1 → res=0x02, cf=1.
  - SRA a=0x80, b=3 → res=0xF0, cf=0.
  - ROR a=0x01, b=1 → res=0x80, cf=1.
  - SRL with b=0 → res=a, cf=0.
- Back-to-back: change func every cycle through all 16 codes with random a/b. Each cycle's outputs match a reference model of the previous cycle's inputs.
